hack_cpu_mc: RTL
================

// Module: hack_cpu_mc
// PURPOSE
//  Multi-cycle, parametrised successor of the single-cycle Hack CPU. Executes the standard 16-bit Hack ISA
//  on a DATA_W-bit datapath (A, D, ALU). Instruction and data memories sit behind req/ack handshakes, so
//  slow or shared RAM/ROM can stall the core. Sits between the instruction ROM and the data RAM/MMIO fabric.
// PARAMETERS
//  DATA_W    16   datapath width (A, D, ALU, data bus); must be >= 16
//  PC_W      15   program counter / instruction address width
//  RESET_PC  0    PC value loaded on reset
// PORTS
//  clk         in   1        single clock; all state updates on rising edge
//  reset       in   1        synchronous, active-high
//  imem_req    out  1        instruction fetch request
//  imem_addr   out  PC_W     fetch address (= PC)
//  imem_ack    in   1        fetch complete; imem_rdata valid this cycle
//  imem_rdata  in   16       instruction word
//  dmem_req    out  1        data access request
//  dmem_we     out  1        1 = write, 0 = read; valid while dmem_req
//  dmem_addr   out  DATA_W   data address
//  dmem_wdata  out  DATA_W   write data
//  dmem_ack    in   1        data access complete; dmem_rdata valid on reads
//  dmem_rdata  in   DATA_W   read data
//  pc          out  PC_W     current PC (debug)
//  retire      out  1        one-cycle pulse when an instruction completes
// BEHAVIOUR
//  Reset: PC=RESET_PC, A=D=0, state=FETCH; all req, dmem_we, retire=0; dmem_addr/dmem_wdata=0.
//   Reset wins over every other event. An in-flight transaction is abandoned; an ack in the reset cycle is ignored.
//  Handshake: req rises with addr/we/wdata stable, held until ack is sampled high at a rising edge.
//   Drops the cycle after ack. Ack in the first req cycle is legal (zero-wait). One outstanding transfer.
//   Ack while req=0 is ignored.
//  FSM:
//   FETCH : imem_req=1; on imem_ack latch IR <- imem_rdata, go DECODE.
//   DECODE: IR[15]=0 (A-instr): A <= zero-extend(IR[14:0]), PC <= PC+1, retire=1, go FETCH.
//           IR[15]=1 and IR[12]=1: go MREAD. Else go EXEC.
//   MREAD : dmem_req=1, we=0, addr=A; on dmem_ack latch MDR <- dmem_rdata, go EXEC.
//   EXEC  : x=D, y=IR[12]?MDR:A. ALU controls zx,nx,zy,ny,f,no = IR[11:6] (Hack semantics, DATA_W bits).
//           Latch WADDR <- A(pre-update) and WDATA <- result.
//           If IR[4], D <= result. If IR[5], A <= result.
//           PC <= A(pre-update)[PC_W-1:0] if jump taken, else PC+1.
//           If IR[3], go MWRITE. Else retire=1, go FETCH.
//   MWRITE: dmem_req=1, we=1, addr=WADDR, wdata=WDATA; on dmem_ack retire=1, go FETCH.
//  Jump: take = IR[2]&ng | IR[1]&zr | IR[0]&~(zr|ng).
//   zr = (result==0); ng = result[DATA_W-1]. Jump target always uses A as it was before EXEC.
//  Arithmetic: two's complement, wraps mod 2^DATA_W, no flags kept between instructions. PC+1 wraps mod 2^PC_W.
//  Latency with zero-wait memories:
//   A-instr or C-instr without M: 2 cycles.
//   +1 cycle if M is read; +1 cycle if M is written (M=M+1: 4 cycles). Each wait cycle adds 1.
//  IR[14:13] of C-instr are ignored. While stalled, all architectural state holds.
// TESTING
//  1 Zero-wait; program @5;D=A;@7;D=D+A;@100;M=D -> one dmem write, addr=100 data=12;
//    retire pulses=6, total 13 cycles.
//  2 Wait states: imem_ack and dmem_ack delayed 3 cycles each -> req held high 4 cycles;
//    addr/wdata stable; results identical to 1.
//  3 Read-modify-write: RAM[100]=41; @100;M=M+1 -> read addr 100, then write addr 100 data 42,
//    in order; the write does not overlap the read.
//  4 Jumps: D=0x7FFF;D=D+1 -> D=0x8000; @20;D;JLT taken -> PC=20. D=0;@20;D;JGT not taken -> PC+1.
//    A=20;AM=D+1;JMP -> jumps to 20.
//  5 Wrap: PC=0x7FFF executing a non-jump -> next fetch at 0. DATA_W=24: @0x7FFF;D=-A -> D=0xFF8001.
//  6 Reset mid-MWRITE with dmem_ack high the same cycle -> no retire; next cycle imem_req=1,
//    imem_addr=RESET_PC, A=D=0.

Source files
------------

// File: rtl/hack_cpu_mc.sv
// Multi-cycle Hack CPU with req/ack instruction and data memory ports.
// ALU work is done in DECODE, or on the MREAD ack for M operands, so no separate execute cycle is spent.

module hack_cpu_mc #(
  parameter int              DATA_W   = 16,
  parameter int              PC_W     = 15,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [PC_W-1:0]   pc,
  output logic              retire
);

  typedef enum logic [1:0] {S_FETCH, S_DECODE, S_MREAD, S_MWRITE} state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d, pc_inc;
  logic [DATA_W-1:0] areg_q, areg_d, dreg_q, dreg_d;
  logic [15:0]       ir_q, ir_d;
  logic [DATA_W-1:0] dmem_addr_q, dmem_addr_d, dmem_wdata_q, dmem_wdata_d;
  logic              retire_q, retire_d;
  logic [DATA_W-1:0] alu_x, alu_y, alu_r;
  logic              zr, ng, take, exec_now;

  // NOTE: blocking assignments inside always_comb are intentional; each line refines the previous value.
  always_comb begin
    alu_x = ir_q[11] ? '0 : dreg_q;
    if (ir_q[10]) alu_x = ~alu_x;
    alu_y = ir_q[9] ? '0 : (ir_q[12] ? dmem_rdata : areg_q);
    if (ir_q[8]) alu_y = ~alu_y;
    alu_r = ir_q[7] ? (alu_x + alu_y) : (alu_x & alu_y);
    if (ir_q[6]) alu_r = ~alu_r;
  end

  assign zr     = (alu_r == '0);
  assign ng     = alu_r[DATA_W-1];
  assign take   = (ir_q[2] & ng) | (ir_q[1] & zr) | (ir_q[0] & ~(zr | ng));
  assign pc_inc = pc_q + PC_W'(1);

  always_comb begin
    // NOTE: every variable gets a hold/default value first, so no path can infer a latch.
    state_d      = state_q;
    pc_d         = pc_q;
    areg_d       = areg_q;
    dreg_d       = dreg_q;
    ir_d         = ir_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    retire_d     = 1'b0;
    exec_now     = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!ir_q[15]) begin
          areg_d   = {{(DATA_W-15){1'b0}}, ir_q[14:0]};
          pc_d     = pc_inc;
          retire_d = 1'b1;
          state_d  = S_FETCH;
        end else if (ir_q[12]) begin
          dmem_addr_d = areg_q;
          state_d     = S_MREAD;
        end else begin
          exec_now = 1'b1;
        end
      end
      S_MREAD: begin
        if (dmem_ack) exec_now = 1'b1;
      end
      S_MWRITE: begin
        if (dmem_ack) begin
          retire_d = 1'b1;
          state_d  = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase

    // Write address and jump target both use A as it was before this instruction.
    if (exec_now) begin
      if (ir_q[4]) dreg_d = alu_r;
      if (ir_q[5]) areg_d = alu_r;
      pc_d = take ? areg_q[PC_W-1:0] : pc_inc;
      if (ir_q[3]) begin
        dmem_addr_d  = areg_q;
        dmem_wdata_d = alu_r;
        state_d      = S_MWRITE;
      end else begin
        retire_d = 1'b1;
        state_d  = S_FETCH;
      end
    end
  end

  // NOTE: synchronous reset, checked first so it overrides any ack arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      areg_q       <= '0;
      dreg_q       <= '0;
      ir_q         <= '0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      retire_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      areg_q       <= areg_d;
      dreg_q       <= dreg_d;
      ir_q         <= ir_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      retire_q     <= retire_d;
    end
  end

  // Requests are masked while reset is held, so an abandoned transfer ends at once.
  assign imem_req   = !reset && (state_q == S_FETCH);
  assign dmem_req   = !reset && ((state_q == S_MREAD) || (state_q == S_MWRITE));
  assign dmem_we    = !reset && (state_q == S_MWRITE);
  assign imem_addr  = pc_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign pc         = pc_q;
  assign retire     = retire_q;

endmodule
